// File: rtl/ddr5_flt_pkg.sv
// Shared state encoding, default timing and sizing helpers for the DDR5
// memory-fault LED scheduler.
package ddr5_flt_pkg;

   localparam logic [2:0] ENC_IDLE   = 3'd0;
   localparam logic [2:0] ENC_SEARCH = 3'd1;
   localparam logic [2:0] ENC_ON     = 3'd2;
   localparam logic [2:0] ENC_OFF    = 3'd3;
   localparam logic [2:0] ENC_GAP    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = ENC_IDLE,
      ST_SEARCH = ENC_SEARCH,
      ST_ON     = ENC_ON,
      ST_OFF    = ENC_OFF,
      ST_GAP    = ENC_GAP
   } ledState_t;

   localparam int DEF_NUM_CH    = 8;
   localparam int DEF_DEB_CYC   = 4;
   localparam int DEF_ON_TICKS  = 3;
   localparam int DEF_OFF_TICKS = 3;
   localparam int DEF_GAP_TICKS = 10;

   // Ceiling log2 with a floor of one bit so single-value ranges still get a wire.
   function automatic int clog2w(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ddr5_flt_debounce.sv
// Per-channel fault qualifier: emits a one-cycle pulse on the cycle a fault
// has been continuously present (while enabled) for DEB_CYC cycles.
module ddr5_flt_debounce
   import ddr5_flt_pkg::*;
#(
   parameter int DEB_CYC = DEF_DEB_CYC
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEnable,
   input  logic iFlt,
   input  logic iClr,
   output logic oQual
);

   logic [7:0] debCnt;
   logic       active;

   // A clear in the same cycle suppresses qualification and restarts the count.
   assign active = iEnable & iFlt & ~iClr;
   assign oQual  = active && (debCnt == 8'(DEB_CYC - 1));

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         debCnt <= '0;
      end else if (!active) begin
         debCnt <= '0;
      end else if (debCnt != 8'(DEB_CYC)) begin
         debCnt <= debCnt + 8'd1;
      end
   end

endmodule

// File: rtl/ddr5_memflt_led_sched.sv
// Latches qualified DDR5 MC power-good faults and drives one shared LED with
// round-robin blink codes (channel k blinks k+1 times, then a gap).
module ddr5_memflt_led_sched
   import ddr5_flt_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int DEB_CYC   = DEF_DEB_CYC,
   parameter int ON_TICKS  = DEF_ON_TICKS,
   parameter int OFF_TICKS = DEF_OFF_TICKS,
   parameter int GAP_TICKS = DEF_GAP_TICKS
) (
   input  logic                        iClk,
   input  logic                        iRst,
   input  logic                        iEnable,
   input  logic                        iTick,
   input  logic [NUM_CH-1:0]           iMemFlt,
   input  logic                        iClrReq,
   output logic                        oClrAck,
   output logic [NUM_CH-1:0]           oFltLatched,
   output logic                        oAnyFlt,
   output logic                        oLedOn,
   output logic [clog2w(NUM_CH)-1:0]   oLedIdx
);

   localparam int IDX_W = clog2w(NUM_CH);
   localparam int TCW   = clog2w(max3(ON_TICKS, OFF_TICKS, GAP_TICKS));
   localparam int PCW   = IDX_W + 1;

   logic              clrReqD;
   logic              clrEdge;
   logic [NUM_CH-1:0] qual;

   ledState_t         state, stateNext;
   logic [TCW-1:0]    tickCnt, tickCntNext, durLast;
   logic [PCW-1:0]    pulseCnt, pulseCntNext, pulseInc, idxPlus;
   logic [IDX_W-1:0]  ptr, ptrNext, idxNext, searchIdx;
   logic              searchHit;

   assign clrEdge = iClrReq & ~clrReqD;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : gDeb
         ddr5_flt_debounce #(
            .DEB_CYC (DEB_CYC)
         ) uDeb (
            .iClk    (iClk),
            .iRst    (iRst),
            .iEnable (iEnable),
            .iFlt    (iMemFlt[g]),
            .iClr    (clrEdge),
            .oQual   (qual[g])
         );
      end
   endgenerate

   // First latched channel at or after the pointer, wrapping around.
   always_comb begin
      int               j;
      logic [IDX_W-1:0] cand;
      searchHit = 1'b0;
      searchIdx = '0;
      j         = 0;
      cand      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_CH) j = j - NUM_CH;
         cand = IDX_W'(j);
         if (!searchHit && oFltLatched[cand]) begin
            searchHit = 1'b1;
            searchIdx = cand;
         end
      end
   end

   always_comb begin
      durLast = '0;
      case (state)
         ST_ON:   durLast = TCW'(ON_TICKS - 1);
         ST_OFF:  durLast = TCW'(OFF_TICKS - 1);
         ST_GAP:  durLast = TCW'(GAP_TICKS - 1);
         default: durLast = '0;
      endcase
   end

   assign pulseInc = pulseCnt + PCW'(1);
   assign idxPlus  = PCW'(oLedIdx) + PCW'(1);

   always_comb begin
      stateNext    = state;
      tickCntNext  = tickCnt;
      pulseCntNext = pulseCnt;
      ptrNext      = ptr;
      idxNext      = oLedIdx;
      case (state)
         ST_IDLE: begin
            if (|oFltLatched) stateNext = ST_SEARCH;
         end
         ST_SEARCH: begin
            tickCntNext  = '0;
            pulseCntNext = '0;
            if (searchHit) begin
               idxNext   = searchIdx;
               stateNext = ST_ON;
            end else begin
               stateNext = ST_IDLE;
            end
         end
         ST_ON, ST_OFF, ST_GAP: begin
            // The entry cycle's tick counts toward the state's duration.
            if (iTick) begin
               if (tickCnt == durLast) begin
                  tickCntNext = '0;
                  if (state == ST_ON) begin
                     pulseCntNext = pulseInc;
                     stateNext    = (pulseInc == idxPlus) ? ST_GAP : ST_OFF;
                  end else if (state == ST_OFF) begin
                     stateNext = ST_ON;
                  end else begin
                     ptrNext   = (oLedIdx == IDX_W'(NUM_CH - 1)) ? '0 : oLedIdx + IDX_W'(1);
                     stateNext = (|oFltLatched) ? ST_SEARCH : ST_IDLE;
                  end
               end else begin
                  tickCntNext = tickCnt + TCW'(1);
               end
            end
         end
         default: stateNext = ST_IDLE;
      endcase
      if (clrEdge) begin
         stateNext    = ST_IDLE;
         tickCntNext  = '0;
         pulseCntNext = '0;
         ptrNext      = '0;
         idxNext      = '0;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         clrReqD     <= 1'b0;
         oClrAck     <= 1'b0;
         oFltLatched <= '0;
         oAnyFlt     <= 1'b0;
         state       <= ST_IDLE;
         tickCnt     <= '0;
         pulseCnt    <= '0;
         ptr         <= '0;
         oLedIdx     <= '0;
         oLedOn      <= 1'b0;
      end else begin
         clrReqD     <= iClrReq;
         oClrAck     <= clrEdge;
         oFltLatched <= clrEdge ? '0 : (oFltLatched | qual);
         oAnyFlt     <= |oFltLatched;
         state       <= stateNext;
         tickCnt     <= tickCntNext;
         pulseCnt    <= pulseCntNext;
         ptr         <= ptrNext;
         oLedIdx     <= idxNext;
         oLedOn      <= (stateNext == ST_ON);
      end
   end

endmodule

// File: tb/tb_ddr5_memflt_led_sched.sv
// Bench for ddr5_memflt_led_sched: directed tables and sequences plus random
// stimulus against a segment-queue reference model.
module tb_ddr5_memflt_led_sched;

   localparam int NUM_CH    = 8;
   localparam int DEB_CYC   = 4;
   localparam int ON_TICKS  = 3;
   localparam int OFF_TICKS = 3;
   localparam int GAP_TICKS = 10;

   localparam int M_IDLE   = 0;
   localparam int M_SEARCH = 1;
   localparam int M_RUN    = 2;

   logic              iClk = 1'b0;
   logic              iRst = 1'b1;
   logic              iEnable = 1'b0;
   logic              iTick = 1'b0;
   logic [NUM_CH-1:0] iMemFlt = '0;
   logic              iClrReq = 1'b0;
   logic              oClrAck;
   logic [NUM_CH-1:0] oFltLatched;
   logic              oAnyFlt;
   logic              oLedOn;
   logic [2:0]        oLedIdx;

   int checks = 0;
   int errors = 0;

   ddr5_memflt_led_sched #(
      .NUM_CH    (NUM_CH),
      .DEB_CYC   (DEB_CYC),
      .ON_TICKS  (ON_TICKS),
      .OFF_TICKS (OFF_TICKS),
      .GAP_TICKS (GAP_TICKS)
   ) dut (
      .iClk        (iClk),
      .iRst        (iRst),
      .iEnable     (iEnable),
      .iTick       (iTick),
      .iMemFlt     (iMemFlt),
      .iClrReq     (iClrReq),
      .oClrAck     (oClrAck),
      .oFltLatched (oFltLatched),
      .oAnyFlt     (oAnyFlt),
      .oLedOn      (oLedOn),
      .oLedIdx     (oLedIdx)
   );

   always #5 iClk = ~iClk;

   // Reference model: run lengths per channel, and the current blink code as
   // a queue of (level, ticks) segments.
   int                run [NUM_CH];
   logic [NUM_CH-1:0] mLat;
   logic              mAny, mAck, mLed, mPrevClr;
   int                mIdx, mPtr, mMode;
   int                segLvl[$];
   int                segLeft[$];

   function automatic logic bitOf(input logic [NUM_CH-1:0] v, input int k);
      return ((v >> k) & NUM_CH'(1)) != '0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int c = 0; c < NUM_CH; c++) run[c] = 0;
      mLat = '0; mAny = 0; mAck = 0; mLed = 0; mPrevClr = 0;
      mIdx = 0; mPtr = 0; mMode = M_IDLE;
      segLvl.delete(); segLeft.delete();
   endtask

   task automatic modelStep();
      logic              edgeClr, found;
      logic [NUM_CH-1:0] newLat;
      int                k;
      edgeClr  = iClrReq && !mPrevClr;
      mPrevClr = iClrReq;
      mAny     = (mLat != '0);
      newLat   = mLat;
      if (edgeClr) begin
         newLat = '0;
         for (int c = 0; c < NUM_CH; c++) run[c] = 0;
         mMode = M_IDLE; mPtr = 0; mIdx = 0;
         segLvl.delete(); segLeft.delete();
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (iEnable && bitOf(iMemFlt, c)) begin
               run[c] = run[c] + 1;
               if (run[c] == DEB_CYC) newLat = newLat | (NUM_CH'(1) << c);
            end else begin
               run[c] = 0;
            end
         end
         case (mMode)
            M_IDLE: if (mLat != '0) mMode = M_SEARCH;
            M_SEARCH: begin
               found = 0;
               for (int i = 0; i < NUM_CH; i++) begin
                  k = (mPtr + i) % NUM_CH;
                  if (!found && bitOf(mLat, k)) begin found = 1; mIdx = k; end
               end
               if (found) begin
                  for (int p = 0; p <= mIdx; p++) begin
                     segLvl.push_back(1); segLeft.push_back(ON_TICKS);
                     if (p < mIdx) begin segLvl.push_back(0); segLeft.push_back(OFF_TICKS); end
                  end
                  segLvl.push_back(0); segLeft.push_back(GAP_TICKS);
                  mMode = M_RUN;
               end else begin
                  mMode = M_IDLE;
               end
            end
            default: begin
               if (iTick) begin
                  segLeft[0] = segLeft[0] - 1;
                  if (segLeft[0] == 0) begin
                     void'(segLvl.pop_front());
                     void'(segLeft.pop_front());
                     if (segLvl.size() == 0) begin
                        mPtr  = (mIdx + 1) % NUM_CH;
                        mMode = (mLat != '0) ? M_SEARCH : M_IDLE;
                     end
                  end
               end
            end
         endcase
      end
      if (mMode == M_RUN) mLed = (segLvl[0] == 1);
      else                mLed = 0;
      mLat = newLat;
      mAck = edgeClr;
   endtask

   task automatic modelCheck();
      logic [2:0] dIdx, eIdx;
      dIdx = (mMode == M_RUN) ? oLedIdx : 3'd0;
      eIdx = (mMode == M_RUN) ? 3'(mIdx) : 3'd0;
      chk("model", 32'({oFltLatched, oAnyFlt, oClrAck, oLedOn, dIdx}),
                   32'({mLat, mAny, mAck, mLed, eIdx}));
   endtask

   task automatic cyc();
      @(posedge iClk);
      modelStep();
      @(negedge iClk);
      modelCheck();
   endtask

   task automatic doReset();
      iRst = 1'b1; iClrReq = 0; iMemFlt = '0; iTick = 0; iEnable = 1;
      modelReset();
      @(negedge iClk);
      @(negedge iClk);
      iRst = 1'b0;
   endtask

   task automatic waitLed(input logic lvl, input int maxCyc);
      for (int i = 0; i < maxCyc && oLedOn !== lvl; i++) cyc();
      chk("wait_led", 32'(oLedOn), 32'(lvl));
   endtask

   typedef struct {
      logic              en;
      logic [NUM_CH-1:0] flt;
      logic [NUM_CH-1:0] expLat;
      logic              expAny;
      logic              expLed;
   } vec_t;

   vec_t tbl[10];
   int   expPat[$];
   int   gIdx[$];
   int   gCnt[$];
   int   rrIdx[4] = '{1, 6, 1, 6};
   int   rrCnt[4] = '{2, 7, 2, 7};
   logic prevLed;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 3-cycle burst must not latch; the 4th consecutive high cycle does.
      tbl[0] = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 8'h04, 8'h04, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 8'h00, 8'h04, 1'b1, 1'b0};
      tbl[9] = '{1'b1, 8'h00, 8'h04, 1'b1, 1'b1};

      doReset();
      chk("reset_state", 32'({oFltLatched, oAnyFlt, oClrAck, oLedOn, oLedIdx}), 32'd0);

      for (int i = 0; i < 10; i++) begin
         iEnable = tbl[i].en;
         iMemFlt = tbl[i].flt;
         cyc();
         chk($sformatf("deb_lat[%0d]", i), 32'(oFltLatched), 32'(tbl[i].expLat));
         chk($sformatf("deb_any[%0d]", i), 32'(oAnyFlt), 32'(tbl[i].expAny));
         chk($sformatf("deb_led[%0d]", i), 32'(oLedOn), 32'(tbl[i].expLed));
      end

      // Blink code for channel 2 alone: three pulses, then gap plus search cycle.
      for (int p = 0; p < 3; p++) begin
         repeat (ON_TICKS) expPat.push_back(1);
         if (p < 2) repeat (OFF_TICKS) expPat.push_back(0);
      end
      repeat (GAP_TICKS + 1) expPat.push_back(0);
      iTick = 1;
      for (int i = 0; i < 2 * expPat.size(); i++) begin
         chk($sformatf("blink[%0d]", i), 32'(oLedOn), 32'(expPat[i % expPat.size()]));
         if (oLedOn) chk("blink_idx", 32'(oLedIdx), 32'd2);
         cyc();
      end

      // Clear while channel 3 is being displayed, then hold the request high.
      doReset();
      iMemFlt = 8'h08;
      repeat (DEB_CYC) cyc();
      iMemFlt = '0;
      waitLed(1'b1, 20);
      iClrReq = 1;
      cyc();
      chk("clr_lat", 32'(oFltLatched), 32'd0);
      chk("clr_led", 32'(oLedOn), 32'd0);
      chk("clr_ack", 32'(oClrAck), 32'd1);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("clr_hold_ack", 32'(oClrAck), 32'd0);
         chk("clr_hold_led", 32'(oLedOn), 32'd0);
         if (i == 0) chk("clr_any", 32'(oAnyFlt), 32'd0);
      end
      iClrReq = 0;
      cyc();

      // Clear coinciding with qualification wins; debounce restarts from zero.
      doReset();
      iMemFlt = 8'h20;
      repeat (DEB_CYC - 1) cyc();
      iClrReq = 1;
      cyc();
      chk("race_lat", 32'(oFltLatched), 32'd0);
      chk("race_ack", 32'(oClrAck), 32'd1);
      repeat (DEB_CYC - 1) cyc();
      chk("race_relat0", 32'(oFltLatched), 32'd0);
      cyc();
      chk("race_relat1", 32'(oFltLatched), 32'h20);
      iClrReq = 0; iMemFlt = '0;
      cyc();

      // Enable gate.
      doReset();
      iEnable = 0; iMemFlt = 8'hFF; iTick = 1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("gate_lat", 32'(oFltLatched), 32'd0);
         chk("gate_led", 32'(oLedOn), 32'd0);
      end
      iMemFlt = '0; iEnable = 1;

      // Round robin across channels 1 and 6.
      doReset();
      iTick = 1;
      iMemFlt = 8'h42;
      repeat (DEB_CYC) cyc();
      iMemFlt = '0;
      prevLed = 0;
      for (int i = 0; i < 400 && gIdx.size() < 5; i++) begin
         cyc();
         if (oLedOn && !prevLed) begin
            if (gIdx.size() == 0 || gIdx[$] != int'(oLedIdx)) begin
               gIdx.push_back(int'(oLedIdx));
               gCnt.push_back(1);
            end else begin
               gCnt[gCnt.size() - 1] = gCnt[gCnt.size() - 1] + 1;
            end
         end
         prevLed = oLedOn;
      end
      chk("rr_ngroups", 32'(gIdx.size() >= 5), 32'd1);
      for (int i = 0; i < 4 && i < gIdx.size(); i++) begin
         chk($sformatf("rr_idx[%0d]", i), 32'(gIdx[i]), 32'(rrIdx[i]));
         chk($sformatf("rr_cnt[%0d]", i), 32'(gCnt[i]), 32'(rrCnt[i]));
      end

      // Async reset while in an inter-pulse off interval.
      for (int i = 0; i < 100 && !(mMode == M_RUN && segLvl[0] == 0 && segLvl.size() > 1); i++) cyc();
      chk("rst_in_off_reached", 32'(mMode == M_RUN && segLvl.size() > 1), 32'd1);
      iRst = 1;
      #1;
      chk("rst_async", 32'({oFltLatched, oAnyFlt, oClrAck, oLedOn, oLedIdx}), 32'd0);
      modelReset();
      @(negedge iClk);
      @(negedge iClk);
      iRst = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         chk("post_rst_led", 32'(oLedOn), 32'd0);
         chk("post_rst_lat", 32'(oFltLatched), 32'd0);
      end
      iMemFlt = 8'h01;
      repeat (DEB_CYC) cyc();
      iMemFlt = '0;
      waitLed(1'b1, 20);
      chk("requal_idx", 32'(oLedIdx), 32'd0);

      // Random stimulus against the model.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         iEnable = ($urandom_range(0, 9) != 0);
         for (int c = 0; c < NUM_CH; c++)
            if ($urandom_range(0, 4) == 0) iMemFlt = iMemFlt ^ (NUM_CH'(1) << c);
         if ((i % 700) > 600) iMemFlt = '0;
         iTick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 119) == 0) iClrReq = ~iClrReq;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr5_memflt_led_sched.md
Name: ddr5_memflt_led_sched

Overview:
- Qualifies and latches per-channel DDR5 memory-controller power-good fault indications for both CPU sockets.
- Schedules a single shared front-panel fault LED across all latched channels using round-robin blink codes. Channel k blinks k+1 times, then a gap, then the next latched channel.
- Sits between the per-MC pwrgd fault sources and the board LED/SGPIO output. Owns the software/BMC clear handshake.

Parameters:
- NUM_CH, 8, number of fault channels (2 sockets x 4 MCs); 2..16.
- DEB_CYC, 4, consecutive iClk cycles a fault must be high to qualify; 1..255.
- ON_TICKS, 3, iTick strobes per LED-on pulse; >=1.
- OFF_TICKS, 3, iTick strobes per LED-off interval between pulses; >=1.
- GAP_TICKS, 10, iTick strobes of LED-off gap after a channel's code; >=1.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous, active-high reset.
- iEnable  in  1  fault qualification window; faults ignored and debounce counters held at 0 while low.
- iTick  in  1  single-cycle timebase strobe (e.g. 1 ms).
- iMemFlt  in  NUM_CH  raw per-channel fault inputs.
- iClrReq  in  1  level clear request.
- oClrAck  out  1  one-cycle acknowledge.
- oFltLatched  out  NUM_CH  sticky qualified faults.
- oAnyFlt  out  1  OR of oFltLatched.
- oLedOn  out  1  shared LED drive, active-high.
- oLedIdx  out  clog2(NUM_CH)  channel currently displayed; valid when FSM not IDLE.

Behaviour:
- Reset (async, iRst=1): all outputs 0, debounce counters 0, FSM IDLE, scan pointer 0, clear-edge register 0.
- Debounce, per channel:
  - Saturating counter increments each cycle iEnable & iMemFlt[k] is high, and resets to 0 otherwise.
  - On the cycle the counter reaches DEB_CYC, oFltLatched[k] sets (registered, visible the next cycle).
  - With DEB_CYC=1, a single-cycle high fault latches.
- Latched bits are sticky. Only the clear handshake clears them; iEnable dropping does not.
- oAnyFlt is registered from oFltLatched, so it lags oFltLatched by one cycle.
- Clear handshake:
  - A rising edge of iClrReq (registered edge detect) clears in that cycle: all latches, all debounce counters, FSM to IDLE, oLedOn=0, pointer=0.
  - oClrAck pulses high for exactly one cycle, the cycle after the edge is detected.
  - Holding iClrReq high does not generate further acks.
  - If a fault qualifies in the same cycle as the clear, the clear wins and debounce restarts from 0.
- Scheduler FSM, all counting advanced only on iTick, tick counter width sized from max(ON,OFF,GAP):
  - IDLE: if any latched bit is set, go to SEARCH.
  - SEARCH (1 clk): select the first latched channel at or after the pointer, wrapping around NUM_CH. Load oLedIdx, pulse count=0, go to ON.
  - ON: oLedOn=1 for ON_TICKS ticks. Then pulse count++. If pulse count == oLedIdx+1, go to GAP; else go to OFF.
  - OFF: oLedOn=0 for OFF_TICKS ticks, then go to ON.
  - GAP: oLedOn=0 for GAP_TICKS ticks. Then pointer = oLedIdx+1 (wrapping to 0), go to SEARCH. If no latched bit is set, go to IDLE.
- oLedOn is a registered output and is 0 in every state except ON.
- A channel latched mid-code does not interrupt the current code. It is picked up at the next SEARCH.
- A single latched channel repeats its code with GAP separation indefinitely.
- iTick coincident with a state-entry cycle counts toward the new state's duration.

Decomposition:
- Shared package ddr5_flt_pkg holds:
  - FSM state encoding (IDLE, SEARCH, ON, OFF, GAP) as localparams.
  - Default timing constants.
  - The clog2 width function.
- Natural sub-module ddr5_flt_debounce: one instance per channel via generate. Ports: clock, reset, enable, fault, clear; output qualified pulse.
- Latch register, clear handshake, and FSM live in the top module.

Test Plan:
- Debounce: DEB_CYC=4, iEnable=1, iMemFlt[2] high 3 cycles then low, then high 4 cycles -> no latch after the 3-cycle burst; oFltLatched=8'h04 on the cycle after the 4th high cycle; oAnyFlt=1 one cycle later.
- Enable gate: iEnable=0 with iMemFlt=8'hFF for 20 cycles -> oFltLatched stays 0; oLedOn stays 0.
- Blink code: only channel 2 latched, ON=OFF=3, GAP=10 -> oLedIdx=2 with exactly 3 oLedOn pulses of 3 ticks each, separated by 3-tick offs, then 10 ticks off, then repeat.
- Round-robin: channels 1 and 6 latched -> sequence is 2 pulses (idx 1), gap, 7 pulses (idx 6), gap, wrap to idx 1; channels 0 and 2–5 never displayed.
- Clear: iClrReq rising while in ON with channel 3 latched -> the next cycle oFltLatched=0, oLedOn=0, FSM IDLE, oClrAck=1 for one cycle; holding iClrReq high for 10 more cycles gives no second ack.
- Reset mid-operation: assert iRst during OFF with faults latched -> all outputs 0 immediately (async); after deassertion, no LED activity until a fault requalifies.
